// File: rtl/parking_slot_controller_pkg.sv
// Shared types and helpers for the parking slot controller.
package parking_pkg;

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned GATE_W    = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_IN  = 2'd1,
    GATE_OUT = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/parking_slot_controller_slot_finder.sv
// Lowest-index free slot finder over the occupancy map.
module slot_finder
  import parking_pkg::*;
(
  input  logic [7:0]        occ,
  output logic [SLOT_W-1:0] idx,
  output logic              none_free
);

  always_comb begin
    idx       = '0;
    none_free = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!occ[i] && none_free) begin
        idx       = SLOT_W'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/parking_slot_controller.sv
// Parking occupancy owner: sequences entry/exit transactions and drives the gate.
module parking_slot_controller #(
  parameter int unsigned NUM_SLOTS   = 8,
  parameter int unsigned GATE_CYCLES = 4,
  parameter logic [7:0]  INIT_OCC    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] exit_slot,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       entry_reject,
  output logic       exit_err,
  output logic [2:0] assigned_slot,
  output logic       gate_open,
  output logic [7:0] occupancy,
  output logic [3:0] free_count,
  output logic       full
);
  import parking_pkg::*;

  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [7:0]          occ_q, occ_d;
  logic [3:0]          free_q, free_d;
  logic                full_q, full_d;
  logic [SLOT_W-1:0]   assigned_q, assigned_d;
  logic [GATE_W-1:0]   cnt_q, cnt_d;
  logic                entry_ack_q, entry_ack_d;
  logic                exit_ack_q, exit_ack_d;
  logic                exit_err_q, exit_err_d;
  logic                reject_q, reject_d;
  logic                gate_q, gate_d;

  logic [SLOT_W-1:0]   free_idx;
  logic                none_free;

  slot_finder u_finder (
    .occ       (occ_q),
    .idx       (free_idx),
    .none_free (none_free)
  );

  always_comb begin
    state_d     = state_q;
    occ_d       = occ_q;
    assigned_d  = assigned_q;
    cnt_d       = cnt_q;
    entry_ack_d = 1'b0;
    exit_ack_d  = 1'b0;
    exit_err_d  = 1'b0;
    reject_d    = 1'b0;
    gate_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (exit_req) begin
          if (occ_q[exit_slot]) begin
            occ_d[exit_slot] = 1'b0;
            exit_ack_d       = 1'b1;
            gate_d           = 1'b1;
            cnt_d            = GATE_LOAD;
            state_d          = GATE_OUT;
          end else begin
            exit_err_d = 1'b1;
            state_d    = WAIT_REL;
          end
        end else if (entry_req) begin
          if (none_free) begin
            reject_d = 1'b1;
          end else begin
            occ_d[free_idx] = 1'b1;
            assigned_d      = free_idx;
            entry_ack_d     = 1'b1;
            gate_d          = 1'b1;
            cnt_d           = GATE_LOAD;
            state_d         = GATE_IN;
          end
        end
      end
      GATE_IN, GATE_OUT: begin
        if (cnt_q == '0) begin
          state_d = WAIT_REL;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          gate_d = 1'b1;
        end
      end
      WAIT_REL: begin
        if (!entry_req && !exit_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flags track the post-update map so they never lag occupancy.
    free_d = 4'(NUM_SLOTS) - popcount8(occ_d);
    full_d = &occ_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      occ_q       <= INIT_OCC;
      free_q      <= 4'(NUM_SLOTS) - popcount8(INIT_OCC);
      full_q      <= &INIT_OCC;
      assigned_q  <= '0;
      cnt_q       <= '0;
      entry_ack_q <= 1'b0;
      exit_ack_q  <= 1'b0;
      exit_err_q  <= 1'b0;
      reject_q    <= 1'b0;
      gate_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      free_q      <= free_d;
      full_q      <= full_d;
      assigned_q  <= assigned_d;
      cnt_q       <= cnt_d;
      entry_ack_q <= entry_ack_d;
      exit_ack_q  <= exit_ack_d;
      exit_err_q  <= exit_err_d;
      reject_q    <= reject_d;
      gate_q      <= gate_d;
    end
  end

  assign entry_ack     = entry_ack_q;
  assign exit_ack      = exit_ack_q;
  assign entry_reject  = reject_q;
  assign exit_err      = exit_err_q;
  assign assigned_slot = assigned_q;
  assign gate_open     = gate_q;
  assign occupancy     = occ_q;
  assign free_count    = free_q;
  assign full          = full_q;

endmodule

// File: doc/parking_slot_controller.md
Name: parking_slot_controller

Overview:
- Sequential controller that owns the 8-slot parking occupancy map and sequences entry and exit transactions.
- Accepts car entry and exit requests, allocates the lowest free slot, releases slots on exit and drives the gate for a fixed number of cycles.
- Enforces a request/acknowledge handshake, so one held request never allocates twice.
- Sits between the entry/exit sensor logic and the gate/display logic; it is the single writer of parking occupancy.

Parameters:
- NUM_SLOTS, 8, number of slots; fixed at 8, slot index width 3.
- GATE_CYCLES, 4, cycles gate_open stays high per transaction; legal range 1..255.
- INIT_OCC, 8'h00, occupancy value loaded on reset; bit i = 1 means slot i is taken.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- entry_req  in  1  level request from the entry sensor; held until the transaction completes.
- exit_req  in  1  level request from the exit sensor; held until the transaction completes.
- exit_slot  in  3  slot being vacated; valid while exit_req is high.
- entry_ack  out  1  one-cycle pulse: slot allocated.
- exit_ack  out  1  one-cycle pulse: slot released.
- entry_reject  out  1  high while entry is refused because the lot is full.
- exit_err  out  1  one-cycle pulse: exit_slot was not occupied.
- assigned_slot  out  3  slot granted by the last entry; holds until the next entry_ack.
- gate_open  out  1  gate drive.
- occupancy  out  8  current occupancy map.
- free_count  out  4  number of zero bits in occupancy, 0..8.
- full  out  1  occupancy == 8'hFF.

Behaviour:
- Reset state (rst sampled high at an edge): state=IDLE, occupancy=INIT_OCC, free_count=popcount-derived value of INIT_OCC, full accordingly, assigned_slot=0, all acks/errors/gate_open=0, gate counter=0.
- Reset mid-transaction aborts it immediately with no partial update.
- All outputs are registered.
- States: IDLE, GATE_IN, GATE_OUT, WAIT_REL.
- IDLE, exit_req=1 (exit has priority over a simultaneous entry_req):
  - If occupancy[exit_slot]=1: clear the bit, exit_ack=1 next cycle, go to GATE_OUT.
  - If occupancy[exit_slot]=0: exit_err=1 next cycle, go to WAIT_REL, occupancy unchanged.
- IDLE, exit_req=0, entry_req=1:
  - If not full: set the lowest-index zero bit, latch its index into assigned_slot, entry_ack=1 next cycle, go to GATE_IN.
  - If full: entry_reject=1 next cycle and remain in IDLE.
  - entry_reject stays high each cycle entry_req=1 and full=1 in IDLE, and drops the cycle after either condition clears.
- Latency: request sampled at edge N. At edge N, occupancy, free_count, full and assigned_slot update and the ack rises. gate_open is high for cycles N+1 .. N+GATE_CYCLES (exactly GATE_CYCLES cycles).
- GATE_IN/GATE_OUT: the counter loads GATE_CYCLES-1 on entry to the state and decrements each cycle. At counter=0 the state moves to WAIT_REL and gate_open drops.
  - Requests are ignored during these states.
  - A slot freed by an exit is not reusable until the controller returns to IDLE.
- WAIT_REL: remain until entry_req=0 and exit_req=0 in the same cycle, then go to IDLE. This prevents re-triggering from a held level request.
- Width rules:
  - free_count = 8 - popcount(occupancy), 4 bits, never wraps.
  - full and free_count are recomputed from the next occupancy value, so they are consistent with occupancy in the same cycle.
- Acks and exit_err are single-cycle pulses and are never high simultaneously.

Decomposition:
- Shared package parking_pkg:
  - NUM_SLOTS, SLOT_W=3, GATE_W=8.
  - State encoding: IDLE=2'd0, GATE_IN=2'd1, GATE_OUT=2'd2, WAIT_REL=2'd3.
- Sub-module slot_finder: combinational lowest-zero-bit priority encoder. Input occ[7:0]; outputs idx[2:0] and none_free.
- Sub-module popcount8 is optional; it may be inline.

Test Plan:
- Reset with INIT_OCC=8'h00, then hold entry_req high: entry_ack pulses 1 cycle after the sample edge, assigned_slot=0, occupancy=8'h01, free_count=7, gate_open high exactly 4 cycles. No second ack until entry_req drops for at least 1 cycle.
- INIT_OCC=8'h57, one entry: assigned_slot=3, occupancy=8'h5F, free_count=2.
- INIT_OCC=8'hFF, entry_req high 5 cycles: entry_reject high for those cycles, no ack, gate_open stays 0, occupancy unchanged. Then exit_req with exit_slot=5: exit_ack, occupancy=8'hDF, full=0.
- Simultaneous entry_req and exit_req with exit_slot=2, occupancy=8'h04: exit serviced (occupancy=8'h00, exit_ack), entry ignored until both drop, then a fresh entry gets slot 0.
- exit_req with exit_slot=6 while occupancy=8'h01: exit_err pulse, occupancy stays 8'h01, gate_open stays 0.
- rst asserted during cycle 2 of GATE_IN: next cycle gate_open=0, state IDLE, occupancy=INIT_OCC, entry_ack=0.
